// File: rtl/ob_deskew_writer.sv
// Purpose: deskew systolic-array column results into row-aligned words, narrow each
//          lane ACC_WIDTH->WIDTH, and write them to ob_mem from a configured offset.
// Latency: lane-0 element at cycle T (lane c at T+c) is written in cycle T+COL; one row/cycle.
// Backpressure: none; ob_mem always accepts, rows outside RUN or past the last row are dropped.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  one-cycle pulse in IDLE: latch o_offset_i / rows_m1_i, start job
//   col_valid_i, col_data_i  skewed per-column valids and signed accumulator results
//   ob_mem_*_o               registered ob_mem write port (cenb/wenb active low)
//   busy_o, done_o, err_o    job running, one-cycle completion pulse, sticky skew error
//
// Build option: define OB_SATURATE_EN for signed saturation instead of truncation.
module ob_deskew_writer #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COL       = 4,
  parameter int O_SIZE    = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [$clog2(O_SIZE)-1:0]  o_offset_i,
  input  logic [$clog2(O_SIZE)-1:0]  rows_m1_i,
  input  logic [COL-1:0]             col_valid_i,
  input  logic [COL*ACC_WIDTH-1:0]   col_data_i,
  output logic                       ob_mem_cenb_o,
  output logic                       ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0]  ob_mem_addr_o,
  output logic [COL*WIDTH-1:0]       ob_mem_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int AW = $clog2(O_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               r_state;
  logic [AW-1:0]        r_offset;
  logic [AW-1:0]        r_rows_m1;
  logic [AW-1:0]        r_row_cnt;
  logic                 r_cenb;
  logic                 r_wenb;
  logic [AW-1:0]        r_addr;
  logic [COL*WIDTH-1:0] r_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic [COL-1:0]       w_av;
  logic [COL*WIDTH-1:0] w_word;
  logic                 w_dl_clr;

  // Delay lines only carry data while a job runs, so stale valids never
  // leak into the next job.
  assign w_dl_clr = rst_i || (r_state != ST_RUN);

  function automatic logic [WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
`ifdef OB_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;
    if (v > SAT_MAX) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return WIDTH'(v);
    end
`else
    return WIDTH'(v);
`endif
  endfunction

  // Lane c is delayed by COL-1-c cycles so every lane of a row lines up with
  // the last (undelayed) lane.
  for (genvar c = 0; c < COL; c++) begin : g_lane
    localparam int D = COL - 1 - c;
    logic signed [ACC_WIDTH-1:0] w_lane_dat;

    if (D == 0) begin : g_thru
      assign w_av[c]    = col_valid_i[c];
      assign w_lane_dat = col_data_i[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [D-1:0]         r_vld;
      logic [ACC_WIDTH-1:0] r_dat [D];

      always_ff @(posedge clk_i) begin
        if (w_dl_clr) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= col_valid_i[c];
          for (int k = 1; k < D; k++) begin
            r_vld[k] <= r_vld[k-1];
          end
        end
        r_dat[0] <= col_data_i[c*ACC_WIDTH +: ACC_WIDTH];
        for (int k = 1; k < D; k++) begin
          r_dat[k] <= r_dat[k-1];
        end
      end

      assign w_av[c]    = r_vld[D-1];
      assign w_lane_dat = r_dat[D-1];
    end

    assign w_word[c*WIDTH +: WIDTH] = narrow(w_lane_dat);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_offset  <= '0;
      r_rows_m1 <= '0;
      r_row_cnt <= '0;
      r_cenb    <= 1'b1;
      r_wenb    <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cenb <= 1'b1;
          r_wenb <= 1'b1;
          if (start_i) begin
            r_offset  <= o_offset_i;
            r_rows_m1 <= rows_m1_i;
            r_row_cnt <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (&w_av) begin
            r_cenb    <= 1'b0;
            r_wenb    <= 1'b0;
            r_addr    <= r_offset + r_row_cnt;  // wraps naturally at O_SIZE
            r_data    <= w_word;
            r_row_cnt <= r_row_cnt + 1'b1;
            if (r_row_cnt == r_rows_m1) begin
              r_state <= ST_DONE;
            end
          end else begin
            // A partial aligned vector means the skew was broken: flag it and
            // drop the word without consuming a row slot.
            r_cenb <= 1'b1;
            r_wenb <= 1'b1;
            if (|w_av) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_cenb  <= 1'b1;
          r_wenb  <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ob_mem_cenb_o = r_cenb;
  assign ob_mem_wenb_o = r_wenb;
  assign ob_mem_addr_o = r_addr;
  assign ob_mem_data_o = r_data;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ob_deskew_writer.sv
// Testbench for ob_deskew_writer: table-driven single-row narrowing jobs, directed
// multi-cycle sequences (basic, skew error, wrap, reset mid-job, full-depth wrap) and
// randomized jobs checked against a row-level reference model.
module tb_ob_deskew_writer;

  localparam int COL   = 4;
  localparam int WIDTH = 8;
  localparam int ACC   = 16;
  localparam int OS    = 256;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_i = 1'b0;
  logic [7:0]           o_offset_i = '0;
  logic [7:0]           rows_m1_i = '0;
  logic [COL-1:0]       col_valid_i = '0;
  logic [COL*ACC-1:0]   col_data_i = '0;
  logic                 ob_mem_cenb_o;
  logic                 ob_mem_wenb_o;
  logic [7:0]           ob_mem_addr_o;
  logic [COL*WIDTH-1:0] ob_mem_data_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  always #5 clk = ~clk;

  ob_deskew_writer #(.WIDTH(WIDTH), .ACC_WIDTH(ACC), .COL(COL), .O_SIZE(OS)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .o_offset_i(o_offset_i), .rows_m1_i(rows_m1_i),
    .col_valid_i(col_valid_i), .col_data_i(col_data_i),
    .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o),
    .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_o(ob_mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          c;
    logic        busy;
    logic        wenb;
  } wr_t;

  typedef struct {
    int   c;
    logic busy;
  } dn_t;

  wr_t got_q[$];
  dn_t done_q[$];

  // Observed ob_mem writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!ob_mem_cenb_o) got_q.push_back('{ob_mem_addr_o, ob_mem_data_o, cyc, busy_o, ob_mem_wenb_o});
    if (done_o) done_q.push_back('{cyc, busy_o});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference narrowing of one accumulator lane.
  function automatic logic [7:0] nar(input logic [15:0] v);
`ifdef OB_SATURATE_EN
    if ($signed(v) > 16'sd127) return 8'h7F;
    if ($signed(v) < -16'sd128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [63:0] lanes);
    logic [31:0] w;
    for (int c = 0; c < COL; c++) w[c*8 +: 8] = nar(lanes[c*16 +: 16]);
    return w;
  endfunction

  // Stimulus plan: per relative cycle, the input valids/data; plus the list of
  // rows (lane-0 cycle, expected word, correctly skewed or not).
  logic [3:0]  pv [1024];
  logic [63:0] pd [1024];

  typedef struct {
    int          t0;
    logic [31:0] w;
    bit          good;
  } row_t;
  row_t rows[$];

  task automatic clear_plan();
    for (int i = 0; i < 1024; i++) begin
      pv[i] = '0;
      pd[i] = '0;
    end
    rows.delete();
  endtask

  // late >= 0 delays that lane's valid/data by one extra cycle.
  task automatic place_row(input int t0, input logic [63:0] lanes, input int late, input logic [31:0] w);
    for (int c = 0; c < COL; c++) begin
      int t;
      t = t0 + c + ((c == late) ? 1 : 0);
      pv[t][c] = 1'b1;
      pd[t][c*16 +: 16] = lanes[c*16 +: 16];
    end
    rows.push_back('{t0, w, (late < 0)});
  endtask

  task automatic run_job(input logic [7:0] off, input logic [7:0] rm1, input int plen,
                         input int rst_at, input logic exp_err);
    int base;
    int n;
    int last_c;
    bit exp_done;
    wr_t ew[$];
    got_q.delete();
    done_q.delete();
    base = 0;
    @(posedge clk); #1;
    start_i = 1'b1; o_offset_i = off; rows_m1_i = rm1; col_valid_i = '0;
    for (int t = 0; t < plen; t++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (t == 0) begin
        base = cyc;
        chk("busy_after_start", busy_o, 1);
        chk("err_clr_on_start", err_o, 0);
      end
      rst_i = (rst_at >= 0 && t >= rst_at && t < rst_at + 2);
      col_valid_i = pv[t];
      col_data_i = pd[t];
      if (rst_at >= 0 && t == rst_at + 2) begin
        chk("busy_after_rst", busy_o, 0);
        chk("cenb_after_rst", ob_mem_cenb_o, 1);
      end
    end
    rst_i = 1'b0;
    col_valid_i = '0;
    repeat (COL + 4) @(posedge clk);
    #1;
    // Model: the first rm1+1 correctly skewed rows are written in order to
    // consecutive addresses, COL cycles after their lane-0 input.
    n = 0;
    last_c = 0;
    foreach (rows[i]) begin
      if (rows[i].good && n <= int'(rm1) && (rst_at < 0 || rows[i].t0 + COL <= rst_at)) begin
        ew.push_back('{8'(int'(off) + n), rows[i].w, base + rows[i].t0 + COL, 1'b1, 1'b0});
        last_c = rows[i].t0 + COL;
        n++;
      end
    end
    exp_done = (n == int'(rm1) + 1) && (rst_at < 0 || last_c + 1 <= rst_at);
    chk("num_writes", got_q.size(), ew.size());
    for (int i = 0; i < ew.size() && i < got_q.size(); i++) begin
      chk($sformatf("addr[%0d]", i), got_q[i].addr, ew[i].addr);
      chk($sformatf("data[%0d]", i), got_q[i].data, ew[i].data);
      chk($sformatf("wr_cycle[%0d]", i), got_q[i].c, ew[i].c);
      chk($sformatf("wr_busy[%0d]", i), got_q[i].busy, 1);
      chk($sformatf("wenb[%0d]", i), got_q[i].wenb, 0);
    end
    chk("done_count", done_q.size(), exp_done ? 1 : 0);
    if (exp_done && done_q.size() > 0) begin
      chk("done_cycle", done_q[0].c, base + last_c + 1);
      chk("busy_at_done", done_q[0].busy, 0);
    end
    chk("err_end", err_o, exp_err);
    chk("busy_end", busy_o, 0);
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [63:0] lanes;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [63:0] lanes;
    int t;
    int nrows;
    logic [7:0] rm1;

    tbl[0] = '{8'h20, {16'd3, 16'd2, 16'd1, 16'd0}, 32'h03020100};
`ifdef OB_SATURATE_EN
    tbl[1] = '{8'h21, {4{16'h012C}}, 32'h7F7F7F7F};
    tbl[2] = '{8'h22, {4{16'h8000}}, 32'h80808080};
    tbl[4] = '{8'h24, {16'hFF7F, 16'h0080, 16'hFF80, 16'h007F}, 32'h807F807F};
`else
    tbl[1] = '{8'h21, {4{16'h012C}}, 32'h2C2C2C2C};
    tbl[2] = '{8'h22, {4{16'h8000}}, 32'h00000000};
    tbl[4] = '{8'h24, {16'hFF7F, 16'h0080, 16'hFF80, 16'h007F}, 32'h7F80807F};
`endif
    tbl[3] = '{8'h23, {4{16'hFFFF}}, 32'hFFFFFFFF};

    // Reset state
    rst_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cenb", ob_mem_cenb_o, 1);
    chk("rst_wenb", ob_mem_wenb_o, 1);
    chk("rst_addr", ob_mem_addr_o, 0);
    chk("rst_data", ob_mem_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;

    // Valids in IDLE are ignored
    got_q.delete();
    done_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      col_valid_i = (i < 6) ? 4'hF : 4'h0;
      col_data_i = {$urandom(), $urandom()};
    end
    repeat (6) @(posedge clk);
    #1;
    chk("idle_writes", got_q.size(), 0);
    chk("idle_done", done_q.size(), 0);
    chk("idle_err", err_o, 0);
    chk("idle_busy", busy_o, 0);

    // Table: single-row jobs (rows_m1=0) exercising narrowing; a second row
    // follows and must be discarded.
    for (int i = 0; i < 5; i++) begin
      clear_plan();
      place_row(0, tbl[i].lanes, -1, tbl[i].exp);
      place_row(2, {$urandom(), $urandom()}, -1, 32'h0);
      run_job(tbl[i].off, 8'd0, 2 + COL + 2, -1, 1'b0);
    end

    // Basic job: three back-to-back rows, lane value r*4+c
    clear_plan();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < COL; c++) begin
        lanes[c*16 +: 16] = 16'(r * 4 + c);
      end
      place_row(r, lanes, -1, {8'(r*4+3), 8'(r*4+2), 8'(r*4+1), 8'(r*4)});
    end
    run_job(8'h10, 8'd2, 2 + COL + 2, -1, 1'b0);

    // Skew error: row 1 lane 2 one cycle late, dropped; err sticky
    clear_plan();
    for (int r = 0; r < 4; r++) begin
      lanes = {$urandom(), $urandom()};
      place_row(r * 6, lanes, (r == 1) ? 2 : -1, model_word(lanes));
    end
    run_job(8'h40, 8'd2, 18 + COL + 2, -1, 1'b1);

    // Address wrap
    clear_plan();
    for (int r = 0; r < 4; r++) begin
      lanes = {$urandom(), $urandom()};
      place_row(r, lanes, -1, model_word(lanes));
    end
    run_job(8'hFE, 8'd3, 3 + COL + 2, -1, 1'b0);

    // Reset after the 2nd of 4 rows has been written
    clear_plan();
    for (int r = 0; r < 4; r++) begin
      lanes = {$urandom(), $urandom()};
      place_row(r * 5, lanes, -1, model_word(lanes));
    end
    run_job(8'h80, 8'd3, 15 + COL + 2, 11, 1'b0);

    // Clean job from its own offset after the reset
    clear_plan();
    for (int r = 0; r < 2; r++) begin
      lanes = {$urandom(), $urandom()};
      place_row(r * 2, lanes, -1, model_word(lanes));
    end
    run_job(8'h90, 8'd1, 2 + COL + 2, -1, 1'b0);

    // Full-depth job wrapping through address 0
    clear_plan();
    for (int r = 0; r < OS; r++) begin
      lanes = {$urandom(), $urandom()};
      place_row(r, lanes, -1, model_word(lanes));
    end
    run_job(8'h05, 8'd255, OS - 1 + COL + 2, -1, 1'b0);

    // Randomized jobs: random gaps, offsets, values, optional surplus row
    for (int j = 0; j < 20; j++) begin
      clear_plan();
      rm1 = 8'($urandom_range(0, 7));
      nrows = int'(rm1) + 1 + int'($urandom_range(0, 1));
      t = 0;
      for (int r = 0; r < nrows; r++) begin
        lanes = {$urandom(), $urandom()};
        place_row(t, lanes, -1, model_word(lanes));
        if (r < nrows - 1) t += 1 + int'($urandom_range(0, 3));
      end
      run_job(8'($urandom()), rm1, t + COL + 2, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
